// File: rtl/exc_pkg.sv
// Shared CP0 address map, exception codes and sequencer state encoding.
// Used by exc_sequencer; the optional timer is controlled by EXC_TIMER_EN.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Fixed priority: interrupt > reserved instruction > overflow > syscall.
  function automatic logic [4:0] exc_code(input logic int_p, input logic ri, input logic ov);
    if (int_p)   return EXC_INT;
    else if (ri) return EXC_RI;
    else if (ov) return EXC_OV;
    else         return EXC_SYS;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for level interrupt requests arriving asynchronously to clk.
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer with a minimal CP0 (SR, Cause, EPC) and RUN/HANDLER/HALT FSM.
// Define EXC_TIMER_EN to add the Count/Compare timer interrupt on IP[15].
module exc_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h00000800,
  parameter int          NUM_IRQ    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_cur,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_sys,
  input  logic               exc_ri,
  input  logic               exc_ov,
  input  logic               is_eret,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               has_exp,
  output logic [31:0]        epc,
  output logic [31:0]        exc_vec,
  output logic               eret_go,
  output logic               halted
);

  state_t             state;
  logic [5:0]         im;
  logic               ie;
  logic [4:0]         exc_code_q;
  logic [31:0]        epc_q;
  logic [NUM_IRQ-1:0] irq_s;
  logic [5:0]         ip;
  logic               sync_exc;
  logic               int_p;
  logic               take;
  logic               exl;

  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d   (irq),
    .q   (irq_s)
  );

`ifdef EXC_TIMER_EN
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        timer_pend;

  // A Compare write wins over a match on the same edge so software can always clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      compare_q  <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (cp0_we && cp0_addr == CP0_COUNT) count_q <= cp0_wdata;
      else                                 count_q <= count_q + 32'd1;
      if (cp0_we && cp0_addr == CP0_COMPARE) begin
        compare_q  <= cp0_wdata;
        timer_pend <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_pend <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    ip = '0;
    for (int i = 0; i < NUM_IRQ; i++) ip[i] = irq_s[i];
`ifdef EXC_TIMER_EN
    ip[5] = ip[5] | timer_pend;
`endif
  end

  assign exl      = (state == HANDLER);
  assign sync_exc = exc_ri | exc_ov | exc_sys;
  assign int_p    = ie & (|(ip & im));
  assign take     = (state == RUN) & (sync_exc | int_p);

  assign has_exp  = take & ~rst;
  assign eret_go  = exl & is_eret & ~sync_exc & ~rst;
  assign halted   = (state == HALT);
  assign epc      = epc_q;
  assign exc_vec  = EXC_VECTOR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      im         <= '0;
      ie         <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      if (cp0_we && cp0_addr == CP0_SR) begin
        im <= cp0_wdata[15:10];
        ie <= cp0_wdata[0];
      end
      // Exception capture overrides a same-cycle MTC0 to EPC.
      if (take) begin
        epc_q      <= pc_cur;
        exc_code_q <= exc_code(int_p, exc_ri, exc_ov);
      end else if (cp0_we && cp0_addr == CP0_EPC) begin
        epc_q <= cp0_wdata;
      end
      case (state)
        RUN:     if (take) state <= HANDLER;
        HANDLER: begin
          if (sync_exc)     state <= HALT;
          else if (is_eret) state <= RUN;
        end
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR:      cp0_rdata = {16'b0, im, 8'b0, exl, ie};
      CP0_CAUSE:   cp0_rdata = {16'b0, ip, 3'b0, exc_code_q, 2'b0};
      CP0_EPC:     cp0_rdata = epc_q;
`ifdef EXC_TIMER_EN
      CP0_COUNT:   cp0_rdata = count_q;
      CP0_COMPARE: cp0_rdata = compare_q;
`endif
      default:     cp0_rdata = '0;
    endcase
  end

endmodule
